// File: rtl/pc_next_unit_pkg.sv
// Shared constants, FSM encoding and PC-source selection for the next-PC unit.
package pc_next_unit_pkg;

   localparam int             PC_ADDR_W    = 8;
   localparam int             PC_INC       = 4;
   localparam int             PC_RAS_DEPTH = 4;
   localparam logic [7:0]     PC_RESET_VEC = 8'h00;

   localparam logic [0:0]     ST_BOOT = 1'b0;
   localparam logic [0:0]     ST_RUN  = 1'b1;

   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,
      SEL_BR  = 2'd1,
      SEL_JMP = 2'd2,
      SEL_RET = 2'd3
   } pc_sel_e;

   // Return beats jump/call, which beats a taken branch.
   function automatic pc_sel_e pc_select(input logic ret,
                                         input logic jmp_or_call,
                                         input logic br_taken);
      if (ret)
         return SEL_RET;
      if (jmp_or_call)
         return SEL_JMP;
      if (br_taken)
         return SEL_BR;
      return SEL_SEQ;
   endfunction

endpackage

// File: rtl/pc_next_unit_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty leaves state alone; both conditions raise sticky flags.
module ras_stack
   import pc_next_unit_pkg::*;
#(
   parameter int ADDR_W = PC_ADDR_W,
   parameter int DEPTH  = PC_RAS_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [ADDR_W-1:0] i_data,
   output logic [ADDR_W-1:0] o_top,
   output logic              o_empty,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_overflow,
   output logic              o_underflow
);

   logic [ADDR_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_full;
   logic              w_empty;
   logic [PTR_W-1:0]  w_top_ptr;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_top_ptr = r_wr_ptr - PTR_W'(1);

   // Storage carries no reset: validity is tracked solely by r_count.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_pop)
         r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (i_pop) begin
         if (w_empty) begin
            r_underflow <= 1'b1;
         end else begin
            r_wr_ptr <= w_top_ptr;
            r_count  <= r_count - CNT_W'(1);
         end
      end else if (i_push) begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_full)
            r_overflow <= 1'b1;
         else
            r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_top       = r_mem[w_top_ptr];
   assign o_empty     = w_empty;
   assign o_count     = r_count;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC generator: boot FSM forces the reset vector once, then selects among
// sequential, branch, jump/call and return targets each cycle.
module pc_next_unit
   import pc_next_unit_pkg::*;
#(
   parameter int                ADDR_W    = PC_ADDR_W,
   parameter int                INC       = PC_INC,
   parameter int                RAS_DEPTH = PC_RAS_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
   localparam int               CNT_W     = $clog2(RAS_DEPTH) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_pc_out,
   input  logic              i_stall,
   input  logic              i_branch,
   input  logic              i_zero,
   input  logic [ADDR_W-1:0] i_offset,
   input  logic              i_jump,
   input  logic              i_call,
   input  logic              i_ret,
   input  logic [ADDR_W-1:0] i_jump_target,
   output logic [ADDR_W-1:0] o_pc_in,
   output logic              o_pc_write,
   output logic [CNT_W-1:0]  o_ras_count,
   output logic              o_ras_overflow,
   output logic              o_ras_underflow
);

   logic [0:0]        r_state;

   logic              w_run;
   logic              w_advance;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_seq;
   logic [ADDR_W-1:0] w_branch_tgt;
   logic [ADDR_W-1:0] w_ras_top;
   logic              w_ras_empty;
   logic [ADDR_W-1:0] w_pc_mux;
   pc_sel_e           w_sel;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= ST_BOOT;
      else
         r_state <= ST_RUN;
   end

   assign w_run     = (r_state == ST_RUN);
   assign w_advance = w_run & ~i_stall;
   assign w_pop     = w_advance & i_ret;
   assign w_push    = w_advance & i_call & ~i_ret;

   // Offset is full width, so modular addition already acts as sign extension.
   assign w_seq        = i_pc_out + ADDR_W'(INC);
   assign w_branch_tgt = w_seq + i_offset;

   assign w_sel = pc_select(i_ret, i_jump | i_call, i_branch & i_zero);

   always_comb begin
      w_pc_mux = w_seq;
      case (w_sel)
         SEL_SEQ: w_pc_mux = w_seq;
         SEL_BR:  w_pc_mux = w_branch_tgt;
         SEL_JMP: w_pc_mux = i_jump_target;
         SEL_RET: w_pc_mux = w_ras_empty ? w_seq : w_ras_top;
         default: w_pc_mux = w_seq;
      endcase
   end

   // Reset is used combinationally so the PC load drops the instant it asserts.
   assign o_pc_in    = (i_rst || !w_run) ? RESET_VEC : w_pc_mux;
   assign o_pc_write = ~i_rst & (~w_run | ~i_stall);

   ras_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_data      (w_seq),
      .o_top       (w_ras_top),
      .o_empty     (w_ras_empty),
      .o_count     (o_ras_count),
      .o_overflow  (o_ras_overflow),
      .o_underflow (o_ras_underflow)
   );

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: vector table, directed RAS sequences,
// and a randomized run against a queue-based reference model.
module tb_pc_next_unit;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pc_out;
   logic       stall, branch, zero, jump, call, ret;
   logic [7:0] offset, jump_target;
   logic [7:0] pc_in;
   logic       pc_write;
   logic [2:0] ras_count;
   logic       ras_overflow, ras_underflow;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q_ras [$];
   bit         m_boot;
   bit         m_ovf;
   bit         m_unf;

   typedef struct {
      logic [7:0] pc;
      bit         st, br, z, j, c, r;
      logic [7:0] off, tgt;
      logic [7:0] e_pc;
      bit         e_wr;
   } vec_t;

   vec_t vt [10];

   always #5 clk = ~clk;

   pc_next_unit dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_pc_out        (pc_out),
      .i_stall         (stall),
      .i_branch        (branch),
      .i_zero          (zero),
      .i_offset        (offset),
      .i_jump          (jump),
      .i_call          (call),
      .i_ret           (ret),
      .i_jump_target   (jump_target),
      .o_pc_in         (pc_in),
      .o_pc_write      (pc_write),
      .o_ras_count     (ras_count),
      .o_ras_overflow  (ras_overflow),
      .o_ras_underflow (ras_underflow)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference next-PC from the rules, using integer arithmetic reduced mod 256.
   function automatic logic [7:0] model_pc(input logic [7:0] pc, input bit br, input bit z,
                                           input bit j, input bit c, input bit r,
                                           input logic [7:0] off, input logic [7:0] tgt);
      int t;
      if (m_boot)
         return 8'h00;
      if (r)
         return (q_ras.size() == 0) ? 8'((int'(pc) + 4) % 256) : q_ras[$];
      if (j || c)
         return tgt;
      if (br && z) begin
         t = int'(pc) + 4 + int'($signed(off));
         t = ((t % 256) + 256) % 256;
         return 8'(t);
      end
      return 8'((int'(pc) + 4) % 256);
   endfunction

   // Drive at posedge+1, check at the falling edge, update the model at posedge.
   task automatic cycle(input logic [7:0] pc, input bit st, input bit br, input bit z,
                        input bit j, input bit c, input bit r,
                        input logic [7:0] off, input logic [7:0] tgt,
                        output logic [7:0] got_pc, output bit got_wr);
      logic [7:0] e_pc;
      bit         e_wr;
      pc_out = pc; stall = st; branch = br; zero = z; jump = j; call = c; ret = r;
      offset = off; jump_target = tgt;
      #4;
      e_pc = model_pc(pc, br, z, j, c, r, off, tgt);
      e_wr = m_boot || !st;
      chk("pc_in", pc_in, e_pc);
      chk("pc_write", 8'(pc_write), 8'(e_wr));
      chk("ras_count", 8'(ras_count), 8'(q_ras.size()));
      chk("ras_overflow", 8'(ras_overflow), 8'(m_ovf));
      chk("ras_underflow", 8'(ras_underflow), 8'(m_unf));
      got_pc = pc_in;
      got_wr = pc_write;
      @(posedge clk);
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (!st) begin
         if (r) begin
            if (q_ras.size() == 0)
               m_unf = 1'b1;
            else
               void'(q_ras.pop_back());
         end else if (c) begin
            if (q_ras.size() == D) begin
               void'(q_ras.pop_front());
               m_ovf = 1'b1;
            end
            q_ras.push_back(8'((int'(pc) + 4) % 256));
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_pc_write", 8'(pc_write), 8'h00);
      chk("rst_pc_in", pc_in, 8'h00);
      chk("rst_count", 8'(ras_count), 8'h00);
      chk("rst_overflow", 8'(ras_overflow), 8'h00);
      chk("rst_underflow", 8'(ras_underflow), 8'h00);
      q_ras.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_boot = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] got;
      bit         wr;
      logic [7:0] pc_track;
      logic [7:0] exp_ret [4];

      pc_out = 8'h00; stall = 0; branch = 0; zero = 0; jump = 0; call = 0; ret = 0;
      offset = 8'h00; jump_target = 8'h00;

      // Vector table: RAS stays empty, so any call/ret entry is stalled.
      vt[0] = '{8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
      vt[1] = '{8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF8, 8'h00, 8'h1C, 1'b1};
      vt[2] = '{8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF8, 8'h00, 8'h24, 1'b1};
      vt[3] = '{8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1};
      vt[4] = '{8'h30, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h80, 8'h80, 1'b1};
      vt[5] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h14, 1'b1};
      vt[6] = '{8'h50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h90, 8'h90, 1'b0};
      vt[7] = '{8'h50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h54, 1'b0};
      vt[8] = '{8'h60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h90, 8'h64, 1'b0};
      vt[9] = '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h03, 1'b1};

      do_reset();

      // Boot cycle ignores stall and controls.
      cycle(8'h33, 1, 1, 1, 1, 1, 0, 8'h05, 8'h99, got, wr);
      chk("boot_pc_in", got, 8'h00);
      chk("boot_pc_write", 8'(wr), 8'h01);
      cycle(8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, got, wr);
      chk("first_seq", got, 8'h04);

      for (int i = 0; i < 10; i++) begin
         cycle(vt[i].pc, vt[i].st, vt[i].br, vt[i].z, vt[i].j, vt[i].c, vt[i].r,
               vt[i].off, vt[i].tgt, got, wr);
         chk($sformatf("vec%0d_pc", i), got, vt[i].e_pc);
         chk($sformatf("vec%0d_wr", i), 8'(wr), 8'(vt[i].e_wr));
      end

      // Single call/return pair.
      cycle(8'h10, 0, 0, 0, 0, 1, 0, 8'h00, 8'h40, got, wr);
      chk("call_pc", got, 8'h40);
      chk("call_count", 8'(ras_count), 8'h01);
      cycle(8'h40, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, got, wr);
      chk("ret_pc", got, 8'h14);
      chk("ret_count", 8'(ras_count), 8'h00);

      // Five calls overflow a four-deep stack.
      for (int i = 1; i <= 5; i++)
         cycle(8'(i * 16), 0, 0, 0, 0, 1, 0, 8'h00, 8'hA0, got, wr);
      chk("ovf_count", 8'(ras_count), 8'h04);
      chk("ovf_flag", 8'(ras_overflow), 8'h01);
      exp_ret[0] = 8'h54; exp_ret[1] = 8'h44; exp_ret[2] = 8'h34; exp_ret[3] = 8'h24;
      for (int i = 0; i < 4; i++) begin
         cycle(8'hA0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, got, wr);
         chk($sformatf("pop%0d_pc", i), got, exp_ret[i]);
      end
      cycle(8'h88, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, got, wr);
      chk("underflow_pc", got, 8'h8C);
      chk("underflow_flag", 8'(ras_underflow), 8'h01);
      chk("underflow_count", 8'(ras_count), 8'h00);

      // Stalled call leaves the stack alone; reset mid-sequence drops it.
      cycle(8'h60, 0, 0, 0, 0, 1, 0, 8'h00, 8'hC0, got, wr);
      cycle(8'hC0, 1, 0, 0, 0, 1, 0, 8'h00, 8'hD0, got, wr);
      chk("stall_call_wr", 8'(wr), 8'h00);
      chk("stall_call_count", 8'(ras_count), 8'h01);
      do_reset();

      pc_track = 8'h00;
      for (int n = 0; n < 400; n++) begin
         bit r_st, r_br, r_z, r_j, r_c, r_r;
         r_st = ($urandom_range(0, 99) < 20);
         r_br = ($urandom_range(0, 99) < 30);
         r_z  = ($urandom_range(0, 1) == 1);
         r_j  = ($urandom_range(0, 99) < 10);
         r_c  = ($urandom_range(0, 99) < 25);
         r_r  = ($urandom_range(0, 99) < 25);
         if ($urandom_range(0, 9) == 0)
            pc_track = 8'($urandom_range(0, 255));
         cycle(pc_track, r_st, r_br, r_z, r_j, r_c, r_r,
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), got, wr);
         if (wr)
            pc_track = got;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
